// File: rtl/dual_issue_pkg.sv
// Shared types for the dual-issue issue/hazard sequencer.
//   state_e   : RUN (normal issue), SPLIT (second half of a split pair), FLUSH (branch bubbles)
//   REG_W_DEF : default register-address width
//   R0        : hard-wired zero register, never a hazard source
package dual_issue_pkg;
    localparam int REG_W_DEF = 3;
    localparam logic [REG_W_DEF-1:0] R0 = '0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SPLIT = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;
endpackage

// File: rtl/dual_issue_ctrl_if.sv
// Decode-stage bus between IF/ID, ID/EX and the issue sequencer.
//   master : the pipeline side (drives register fields, hazard inputs; sees controls)
//   slave  : the sequencer (reads fields; drives PC/IF_ID enables, bubbles, counters)
interface dual_issue_ctrl_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] IF_ID_rm_1, IF_ID_rn_1, IF_ID_rd_1;
    logic             IF_ID_RegWrite1;
    logic [REG_W-1:0] IF_ID_rm_2, IF_ID_rn_2, IF_ID_rd_2;
    logic             IF_ID_RegWrite2;
    logic             ID_EX_MemRead1;
    logic [REG_W-1:0] ID_EX_rd_1;
    logic             branch_taken;
    logic             PCWrite, IF_ID_Write, IF_Flush;
    logic             ID_EX_Flush1, ID_EX_Flush2, split_slot;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output IF_ID_rm_1, IF_ID_rn_1, IF_ID_rd_1, IF_ID_RegWrite1,
        output IF_ID_rm_2, IF_ID_rn_2, IF_ID_rd_2, IF_ID_RegWrite2,
        output ID_EX_MemRead1, ID_EX_rd_1, branch_taken,
        input  PCWrite, IF_ID_Write, IF_Flush, ID_EX_Flush1, ID_EX_Flush2, split_slot,
        input  stall_cnt, flush_cnt
    );
    modport slave (
        input  IF_ID_rm_1, IF_ID_rn_1, IF_ID_rd_1, IF_ID_RegWrite1,
        input  IF_ID_rm_2, IF_ID_rn_2, IF_ID_rd_2, IF_ID_RegWrite2,
        input  ID_EX_MemRead1, ID_EX_rd_1, branch_taken,
        output PCWrite, IF_ID_Write, IF_Flush, ID_EX_Flush1, ID_EX_Flush2, split_slot,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/issue_hazard_detect.sv
// Combinational hazard comparators for the fetched pair.
//   i_ex_*          : load in EX pipe 1 (MemRead, destination)
//   i_rm*/i_rn*/... : register fields of the pair in IF/ID
//   o_lu1 / o_lu2   : load-use hazard against pipe 1 / pipe 2 sources
//   o_dep           : pipe 2 depends on pipe 1 (RAW or WAW), pair must split
// Pipe 2's rd is also read (store data), so it is included in both lu2 and dep.
module issue_hazard_detect
    import dual_issue_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic [REG_W-1:0] i_rm1,
    input  logic [REG_W-1:0] i_rn1,
    input  logic [REG_W-1:0] i_rd1,
    input  logic             i_regwrite1,
    input  logic [REG_W-1:0] i_rm2,
    input  logic [REG_W-1:0] i_rn2,
    input  logic [REG_W-1:0] i_rd2,
    output logic             o_lu1,
    output logic             o_lu2,
    output logic             o_dep
);
    logic w_ex_live, w_rd1_live;

    assign w_ex_live  = i_ex_memread && (i_ex_rd != REG_W'(R0));
    assign w_rd1_live = i_regwrite1 && (i_rd1 != REG_W'(R0));

    assign o_lu1 = w_ex_live && ((i_ex_rd == i_rm1) || (i_ex_rd == i_rn1));
    assign o_lu2 = w_ex_live && ((i_ex_rd == i_rm2) || (i_ex_rd == i_rn2) || (i_ex_rd == i_rd2));
    assign o_dep = w_rd1_live && ((i_rd1 == i_rm2) || (i_rd1 == i_rn2) || (i_rd1 == i_rd2));
endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue/hazard sequencer for the two-pipe core (between IF/ID and ID/EX).
// Decides per cycle: dual issue, split across two cycles, load-use stall, or
// branch flush. Outputs decode state and inputs in the same cycle.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dual_issue_ctrl_if.slave (pair fields, EX load info, controls)
// Optional: define STALL_COUNT_EN to build saturating stall/flush counters;
// otherwise stall_cnt/flush_cnt are tied to zero.
// A taken branch squashes the pair in decode on the same cycle it is seen
// (bubbles both pipes, flushes IF/ID, lets the PC load the target).
module dual_issue_ctrl
    import dual_issue_pkg::*;
#(
    parameter int REG_W        = REG_W_DEF,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    dual_issue_ctrl_if.slave  bus
);
    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    state_e          r_state, w_next;
    logic [FC_W-1:0] r_fcnt, w_fcnt_nxt;
    logic            w_lu1, w_lu2, w_dep;
    logic            w_pcw, w_ifidw, w_iff, w_f1, w_f2, w_split;
    logic            w_stall_ev, w_flush_ev;

    issue_hazard_detect #(.REG_W(REG_W)) u_hz (
        .i_ex_memread (bus.ID_EX_MemRead1),
        .i_ex_rd      (bus.ID_EX_rd_1),
        .i_rm1        (bus.IF_ID_rm_1),
        .i_rn1        (bus.IF_ID_rn_1),
        .i_rd1        (bus.IF_ID_rd_1),
        .i_regwrite1  (bus.IF_ID_RegWrite1),
        .i_rm2        (bus.IF_ID_rm_2),
        .i_rn2        (bus.IF_ID_rn_2),
        .i_rd2        (bus.IF_ID_rd_2),
        .o_lu1        (w_lu1),
        .o_lu2        (w_lu2),
        .o_dep        (w_dep)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_fcnt_nxt = r_fcnt;
        w_pcw      = 1'b0;
        w_ifidw    = 1'b0;
        w_iff      = 1'b0;
        w_f1       = 1'b0;
        w_f2       = 1'b0;
        w_split    = 1'b0;
        w_stall_ev = 1'b0;
        w_flush_ev = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.branch_taken) begin
                    {w_pcw, w_ifidw, w_iff, w_f1, w_f2} = '1;
                    w_next     = ST_FLUSH;
                    w_fcnt_nxt = FC_W'(FLUSH_CYCLES);
                end else if (w_lu1 || w_lu2) begin
                    {w_f1, w_f2} = 2'b11;
                    w_stall_ev   = 1'b1;
                end else if (w_dep) begin
                    w_f2   = 1'b1;     // pipe 1 goes alone; pair stays in IF/ID
                    w_next = ST_SPLIT;
                end else begin
                    {w_pcw, w_ifidw} = 2'b11;
                end
            end
            ST_SPLIT: begin
                w_split = 1'b1;
                if (bus.branch_taken) begin
                    {w_pcw, w_ifidw, w_iff, w_f1, w_f2} = '1;
                    w_next     = ST_FLUSH;
                    w_fcnt_nxt = FC_W'(FLUSH_CYCLES);
                end else if (w_lu2) begin
                    {w_f1, w_f2} = 2'b11;
                    w_stall_ev   = 1'b1;
                end else begin
                    {w_pcw, w_ifidw, w_f1} = 3'b111;
                    w_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                {w_pcw, w_ifidw, w_iff, w_f1, w_f2} = '1;
                w_flush_ev = 1'b1;
                // <=1 also recovers from a stray zero count
                if (r_fcnt <= FC_W'(1)) begin
                    w_next     = ST_RUN;
                    w_fcnt_nxt = '0;
                end else begin
                    w_fcnt_nxt = r_fcnt - FC_W'(1);
                end
            end
            default: w_next = ST_RUN;
        endcase
        if (reset) begin
            {w_pcw, w_ifidw, w_iff, w_f1, w_f2, w_split} = 6'b001110;
            w_stall_ev = 1'b0;
            w_flush_ev = 1'b0;
        end
    end

    assign bus.PCWrite      = w_pcw;
    assign bus.IF_ID_Write  = w_ifidw;
    assign bus.IF_Flush     = w_iff;
    assign bus.ID_EX_Flush1 = w_f1;
    assign bus.ID_EX_Flush2 = w_f2;
    assign bus.split_slot   = w_split;

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_ev && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_ev && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    logic w_unused_ev;
    assign w_unused_ev   = w_stall_ev | w_flush_ev;
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif
endmodule
